// File: rtl/param_mode_counter_pkg.sv
// Shared definitions for the parametrised multi-mode sequence counter.
// The 3-bit mode encodings live here so the counter and any block driving
// it agree on the same operation codes.
package param_mode_counter_pkg;

    localparam logic [2:0] MODE_EVEN_UP  = 3'b000;
    localparam logic [2:0] MODE_ODD_UP   = 3'b001;
    localparam logic [2:0] MODE_LOAD     = 3'b010;
    localparam logic [2:0] MODE_HOLD     = 3'b011;
    localparam logic [2:0] MODE_EVEN_DN  = 3'b100;
    localparam logic [2:0] MODE_ODD_DN   = 3'b101;
    localparam logic [2:0] MODE_LOAD_MAX = 3'b110;
    localparam logic [2:0] MODE_CLEAR    = 3'b111;

endpackage

// File: rtl/param_mode_counter.sv
// Parametrised multi-mode sequence counter.
// Counts up or down by an even STEP while keeping parity, loads, holds,
// clears, and pulses wrap for one cycle when a step leaves 0..MAX.
// Optional build macro SATURATE_EN: out-of-range steps clamp to the largest
// (up) or smallest (down) value of the same parity instead of wrapping,
// and wrap pulses on every clamped cycle. Ports are identical either way.
module param_mode_counter
    import param_mode_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int STEP      = 2,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Z,
    output logic             wrap
);

    // Reject parameter sets that would break the parity-preserving scheme.
    if (WIDTH < 2) begin : gWidthCheck
        $error("param_mode_counter: WIDTH must be at least 2");
    end
    if ((STEP % 2) != 0) begin : gStepParityCheck
        $error("param_mode_counter: STEP must be even");
    end
    if (STEP <= 0 || STEP >= (2 ** WIDTH)) begin : gStepRangeCheck
        $error("param_mode_counter: STEP must be in 1..2^WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] RESET_W   = WIDTH'(RESET_VAL);

    logic [WIDTH:0]   upSum;
    logic [WIDTH-1:0] dnDiff;
    logic             upOver;
    logic             dnUnder;
    logic [WIDTH-1:0] upResult;
    logic [WIDTH-1:0] dnResult;
    logic [WIDTH-1:0] nextZ;
    logic             nextWrap;

    // Step arithmetic: the widened sum exposes overflow in its top bit, and
    // the out-of-range result is either the modulo value or a parity-kept
    // clamp to the nearest limit, depending on the build.
    always_comb begin
        upSum   = {1'b0, Z} + STEP_EXT;
        dnDiff  = Z - STEP_W;
        upOver  = upSum[WIDTH];
        dnUnder = ({1'b0, Z} < STEP_EXT);
`ifdef SATURATE_EN
        upResult = upOver  ? {{(WIDTH-1){1'b1}}, Z[0]} : upSum[WIDTH-1:0];
        dnResult = dnUnder ? {{(WIDTH-1){1'b0}}, Z[0]} : dnDiff;
`else
        upResult = upSum[WIDTH-1:0];
        dnResult = dnDiff;
`endif
    end

    // Next-state mux: apply the selected mode when enabled; realign, load,
    // hold and clear never raise wrap, only an out-of-range step does.
    always_comb begin
        nextZ    = Z;
        nextWrap = 1'b0;
        if (en) begin
            case (mode)
                MODE_EVEN_UP: begin
                    if (!Z[0]) begin
                        nextZ    = upResult;
                        nextWrap = upOver;
                    end else begin
                        nextZ = '0;
                    end
                end
                MODE_ODD_UP: begin
                    if (Z[0]) begin
                        nextZ    = upResult;
                        nextWrap = upOver;
                    end else begin
                        nextZ = {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                MODE_LOAD: begin
                    nextZ = load_val;
                end
                MODE_HOLD: begin
                    nextZ = Z;
                end
                MODE_EVEN_DN: begin
                    if (!Z[0]) begin
                        nextZ    = dnResult;
                        nextWrap = dnUnder;
                    end else begin
                        nextZ = MAX_VAL - 1'b1;
                    end
                end
                MODE_ODD_DN: begin
                    if (Z[0]) begin
                        nextZ    = dnResult;
                        nextWrap = dnUnder;
                    end else begin
                        nextZ = MAX_VAL;
                    end
                end
                MODE_LOAD_MAX: begin
                    nextZ = MAX_VAL;
                end
                MODE_CLEAR: begin
                    nextZ = '0;
                end
                default: begin
                    nextZ = Z;
                end
            endcase
        end
    end

    // Count and wrap registers; reset forces the start value immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Z    <= RESET_W;
            wrap <= 1'b0;
        end else begin
            Z    <= nextZ;
            wrap <= nextWrap;
        end
    end

endmodule

// File: tb/tb_param_mode_counter.sv
// Directed bench for param_mode_counter: a 4-bit/step-2 instance driven from
// a vector table plus hand sequences, and an 8-bit/step-4 instance with a
// non-zero reset value for the wide wrap case. Expected values follow the
// SATURATE_EN build macro.
module tb_param_mode_counter;

    localparam logic [2:0] M_EVEN_UP  = 3'b000;
    localparam logic [2:0] M_ODD_UP   = 3'b001;
    localparam logic [2:0] M_LOAD     = 3'b010;
    localparam logic [2:0] M_HOLD     = 3'b011;
    localparam logic [2:0] M_EVEN_DN  = 3'b100;
    localparam logic [2:0] M_ODD_DN   = 3'b101;
    localparam logic [2:0] M_LOAD_MAX = 3'b110;
    localparam logic [2:0] M_CLEAR    = 3'b111;

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [3:0] loadVal;
        logic [3:0] expZ;
        logic       expWrap;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [3:0] loadVal;
    logic [3:0] z;
    logic       wrap;

    logic       en8;
    logic [2:0] mode8;
    logic [7:0] loadVal8;
    logic [7:0] z8;
    logic       wrap8;

    int checkCount;
    int errorCount;
    vec_t vecs[64];
    int numVecs;

    param_mode_counter #(.WIDTH(4), .STEP(2), .RESET_VAL(0)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .load_val(loadVal), .Z(z), .wrap(wrap)
    );

    param_mode_counter #(.WIDTH(8), .STEP(4), .RESET_VAL(100)) dut8 (
        .clk(clk), .reset(reset), .en(en8), .mode(mode8),
        .load_val(loadVal8), .Z(z8), .wrap(wrap8)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic e, input logic [2:0] m, input logic [3:0] lv,
                          input logic [3:0] ez, input logic ew);
        vecs[numVecs].en      = e;
        vecs[numVecs].mode    = m;
        vecs[numVecs].loadVal = lv;
        vecs[numVecs].expZ    = ez;
        vecs[numVecs].expWrap = ew;
        numVecs++;
    endtask

    task automatic applyStimulus(input logic e, input logic [2:0] m, input logic [3:0] lv);
        @(negedge clk);
        en      = e;
        mode    = m;
        loadVal = lv;
    endtask

    task automatic applyStimulus8(input logic e, input logic [2:0] m, input logic [7:0] lv);
        @(negedge clk);
        en8      = e;
        mode8    = m;
        loadVal8 = lv;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actZ, input logic [7:0] expZ,
                               input logic actW, input logic expW);
        checkCount++;
        if (actZ !== expZ) begin
            errorCount++;
            $display("[TB] FAIL %s Z: got %0d, expected %0d", name, actZ, expZ);
        end
        checkCount++;
        if (actW !== expW) begin
            errorCount++;
            $display("[TB] FAIL %s wrap: got %0b, expected %0b", name, actW, expW);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        numVecs    = 0;
        reset      = 1'b0;
        en         = 1'b0;
        mode       = M_HOLD;
        loadVal    = 4'd0;
        en8        = 1'b0;
        mode8      = M_HOLD;
        loadVal8   = 8'd0;

        addVec(1, M_CLEAR,    0, 0,  0);
        addVec(1, M_EVEN_UP,  0, 2,  0);
        addVec(1, M_EVEN_UP,  0, 4,  0);
        addVec(1, M_EVEN_UP,  0, 6,  0);
        addVec(1, M_EVEN_UP,  0, 8,  0);
        addVec(1, M_EVEN_UP,  0, 10, 0);
        addVec(1, M_EVEN_UP,  0, 12, 0);
        addVec(1, M_EVEN_UP,  0, 14, 0);
`ifdef SATURATE_EN
        addVec(1, M_EVEN_UP,  0, 14, 1);
        addVec(1, M_EVEN_UP,  0, 14, 1);
        addVec(0, M_EVEN_UP,  0, 14, 0);
        addVec(1, M_LOAD_MAX, 0, 15, 0);
        addVec(1, M_ODD_UP,   0, 15, 1);
        addVec(1, M_ODD_UP,   0, 15, 1);
        addVec(1, M_LOAD,     5, 5,  0);
`else
        addVec(1, M_EVEN_UP,  0, 0,  1);
        addVec(1, M_EVEN_UP,  0, 2,  0);
        addVec(0, M_EVEN_UP,  0, 2,  0);
        addVec(1, M_LOAD_MAX, 0, 15, 0);
        addVec(1, M_ODD_UP,   0, 1,  1);
        addVec(1, M_ODD_UP,   0, 3,  0);
        addVec(1, M_ODD_UP,   0, 5,  0);
`endif
        addVec(1, M_HOLD,     0, 5,  0);
        addVec(1, M_HOLD,     0, 5,  0);
        addVec(1, M_HOLD,     0, 5,  0);
        addVec(1, M_EVEN_DN,  0, 14, 0);
        addVec(1, M_EVEN_DN,  0, 12, 0);
        addVec(1, M_EVEN_DN,  0, 10, 0);
        addVec(1, M_ODD_UP,   0, 1,  0);
        addVec(1, M_ODD_UP,   0, 3,  0);
        addVec(1, M_LOAD,     2, 2,  0);
        addVec(1, M_EVEN_DN,  0, 0,  0);
`ifdef SATURATE_EN
        addVec(1, M_EVEN_DN,  0, 0,  1);
`else
        addVec(1, M_EVEN_DN,  0, 14, 1);
`endif
        addVec(1, M_ODD_DN,   0, 15, 0);
        addVec(1, M_ODD_DN,   0, 13, 0);
        addVec(1, M_LOAD,     3, 3,  0);
        addVec(1, M_ODD_DN,   0, 1,  0);
`ifdef SATURATE_EN
        addVec(1, M_ODD_DN,   0, 1,  1);
        addVec(1, M_ODD_DN,   0, 1,  1);
        addVec(0, M_EVEN_DN,  0, 1,  0);
`else
        addVec(1, M_ODD_DN,   0, 15, 1);
        addVec(0, M_EVEN_DN,  0, 15, 0);
`endif
        addVec(1, M_EVEN_DN,  0, 14, 0);
        addVec(0, M_LOAD,     9, 14, 0);
        addVec(1, M_LOAD,     9, 9,  0);
        addVec(1, M_EVEN_UP,  0, 0,  0);
        addVec(1, M_LOAD,     9, 9,  0);
        addVec(1, M_CLEAR,    0, 0,  0);
        addVec(1, M_ODD_UP,   0, 1,  0);
        addVec(1, M_LOAD_MAX, 0, 15, 0);
        addVec(1, M_EVEN_UP,  0, 0,  0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset4", {4'd0, z}, 8'd0, wrap, 1'b0);
        checkOutput("reset8", z8, 8'd100, wrap8, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < numVecs; i++) begin
            applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].loadVal);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), {4'd0, z}, {4'd0, vecs[i].expZ},
                        wrap, vecs[i].expWrap);
        end

        // Asynchronous reset in mid-count, then restart from the reset value.
        applyStimulus(1, M_LOAD, 4'd4);
        applyStimulus(1, M_EVEN_UP, 4'd0);
        @(posedge clk);
        #1;
        checkOutput("preReset", {4'd0, z}, 8'd6, wrap, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("asyncReset", {4'd0, z}, 8'd0, wrap, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("resetHeld", {4'd0, z}, 8'd0, wrap, 1'b0);
        checkOutput("resetHeld8", z8, 8'd100, wrap8, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("afterRelease", {4'd0, z}, 8'd2, wrap, 1'b0);

        // Wide instance: step 4 across the top of an 8-bit range.
        applyStimulus8(1, M_LOAD, 8'd248);
        @(posedge clk);
        #1;
        checkOutput("w8load", z8, 8'd248, wrap8, 1'b0);
        applyStimulus8(1, M_EVEN_UP, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("w8step", z8, 8'd252, wrap8, 1'b0);
        @(posedge clk);
        #1;
`ifdef SATURATE_EN
        checkOutput("w8top", z8, 8'd254, wrap8, 1'b1);
`else
        checkOutput("w8top", z8, 8'd0, wrap8, 1'b1);
`endif
        applyStimulus8(1, M_CLEAR, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("w8clear", z8, 8'd0, wrap8, 1'b0);
        applyStimulus8(1, M_EVEN_DN, 8'd0);
        @(posedge clk);
        #1;
`ifdef SATURATE_EN
        checkOutput("w8bottom", z8, 8'd0, wrap8, 1'b1);
`else
        checkOutput("w8bottom", z8, 8'd252, wrap8, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
